fm_config_sequencer: RTL and testbench

Switch-driven configuration controller for the FM audio datapath (message NCO, FM modulator/demodulator, audio output select). It debounces the board switches and maps them to tuning words, deviation and output selection. Every change is applied through a mute → apply → settle sequence so the audio PWM never plays a retuning transient. A sweep mode also steps the message tone automatically.

---
 rtl/fm_config_sequencer.sv | 110 +++++++++++
 tb/tb_fm_config_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fm_config_sequencer.sv
// fm_config_sequencer: debounced switch map driving FM datapath settings through a mute/apply/settle sequence.
module fm_config_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES = 4096,
  parameter int SWEEP_DWELL = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sw,
  output logic [31:0] msg_ctrl,
  output logic [31:0] ctr_ctrl,
  output logic [4:0]  deviation,
  output logic [1:0]  out_sel,
  output logic        mute,
  output logic        busy,
  output logic        cfg_update
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(SWEEP_DWELL + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] DWL_MAX = WW'(SWEEP_DWELL - 1);
  localparam logic [10:0] RST_CFG = 11'h008;
  typedef enum logic [1:0] {IDLE, MUTE, APPLY, SETTLE} state_t;
  state_t state, state_d;
  logic [15:0] sync1, sync2, cand;
  logic [DW-1:0] deb_cnt;
  logic [SW-1:0] set_cnt;
  logic [WW-1:0] dwell;
  // stable/applied hold only {sw[15:10], sw[4:0]}; sw[9:5] still restart the debounce
  logic [10:0] stable, applied;
  logic [1:0] idx, idx_n;
  logic sweep_due, sweep_old, sweep_new, pending, set_done;
  logic [31:0] tone_word, sweep_word, ctr_word;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= 16'h0008;
      sync2 <= 16'h0008;
      cand <= 16'h0008;
      deb_cnt <= '0;
      stable <= RST_CFG;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_MAX) stable <= {cand[15:10], cand[4:0]};
      else deb_cnt <= deb_cnt + DW'(1);
    end
  assign sweep_old = applied[8:7] == 2'b11;
  assign sweep_new = stable[8:7] == 2'b11;
  assign pending = (stable != applied) || sweep_due;
  assign set_done = set_cnt == SET_MAX;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = pending ? MUTE : IDLE;
      MUTE:    state_d = set_done ? APPLY : MUTE;
      APPLY:   state_d = SETTLE;
      default: state_d = set_done ? IDLE : SETTLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= SETTLE;
      set_cnt <= '0;
    end else begin
      state <= state_d;
      set_cnt <= (state_d != state) ? '0 : (state == MUTE || state == SETTLE) ? set_cnt + SW'(1) : set_cnt;
    end
  // dwell only advances while idling in sweep; the due flag is consumed at APPLY
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dwell <= '0;
      sweep_due <= 1'b0;
    end else begin
      dwell <= (state != IDLE || !sweep_old) ? '0 : (dwell != DWL_MAX) ? dwell + WW'(1) : dwell;
      sweep_due <= (state == APPLY || !sweep_old) ? 1'b0 : (state == IDLE && dwell == DWL_MAX) ? 1'b1 : sweep_due;
    end
  always_comb begin
    idx_n = (sweep_new && sweep_old) ? (sweep_due ? ((idx == 2'd2) ? 2'd0 : idx + 2'd1) : idx) : 2'd0;
    tone_word = (stable[8:7] == 2'b00) ? 32'h49D2 : (stable[8:7] == 2'b01) ? 32'h93A4 : 32'h24E9;
    sweep_word = (idx_n == 2'd0) ? 32'h24E9 : (idx_n == 2'd1) ? 32'h49D2 : 32'h93A4;
    ctr_word = (stable[6:5] == 2'b01) ? 32'h3EEA2 : (stable[6:5] == 2'b10) ? 32'hFBA8 : 32'h1F751;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      applied <= RST_CFG;
      idx <= 2'd0;
      msg_ctrl <= 32'h49D2;
      ctr_ctrl <= 32'h1F751;
      deviation <= 5'b01000;
      out_sel <= 2'b00;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= state == APPLY;
      if (state == APPLY) begin
        applied <= stable;
        idx <= idx_n;
        msg_ctrl <= sweep_new ? sweep_word : tone_word;
        ctr_ctrl <= ctr_word;
        deviation <= stable[4:0];
        out_sel <= stable[10:9];
      end
    end
  assign mute = state != IDLE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_fm_config_sequencer.sv
// tb_fm_config_sequencer: scoreboard bench; expected settings are queued at stimulus, popped on cfg_update.
module tb_fm_config_sequencer;
  typedef struct {logic [31:0] m; logic [31:0] c; logic [4:0] d; logic [1:0] o;} exp_t;
  logic clk, reset_n, mute, busy, cfg_update;
  logic [15:0] sw;
  logic [31:0] msg_ctrl, ctr_ctrl;
  logic [4:0] deviation;
  logic [1:0] out_sel;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  fm_config_sequencer #(.DEBOUNCE_CYCLES(8), .SETTLE_CYCLES(4), .SWEEP_DWELL(16)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .msg_ctrl(msg_ctrl), .ctr_ctrl(ctr_ctrl),
    .deviation(deviation), .out_sel(out_sel), .mute(mute), .busy(busy), .cfg_update(cfg_update)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] m, input logic [31:0] c, input logic [4:0] d, input logic [1:0] o);
    exp_t e;
    e.m = m; e.c = c; e.d = d; e.o = o;
    exp_q.push_back(e);
  endtask
  task automatic run(input int n, output int mutes, output int busys, output int upds, output int first);
    mutes = 0; busys = 0; upds = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (mute) mutes++;
      if (busy) busys++;
      if (cfg_update) begin
        upds++;
        if (first == 0) first = i;
      end
    end
  endtask
  task automatic wait_upd(input string nm, input int n);
    int got;
    got = 0;
    for (int i = 0; i < n && got == 0; i++) begin
      @(negedge clk);
      if (cfg_update) got = 1;
    end
    if (got == 0) chk(nm, 0, 0, 1);
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_msg"}, msg_ctrl == 32'h49D2, msg_ctrl, 32'h49D2);
    chk({nm, "_ctr"}, ctr_ctrl == 32'h1F751, ctr_ctrl, 32'h1F751);
    chk({nm, "_dev"}, deviation == 5'h08, deviation, 5'h08);
    chk({nm, "_sel"}, out_sel == 2'b00, out_sel, 0);
    chk({nm, "_mute"}, mute == 1'b1, mute, 1);
    chk({nm, "_busy"}, busy == 1'b1, busy, 1);
    chk({nm, "_upd"}, cfg_update == 1'b0, cfg_update, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && cfg_update) begin
        if (exp_q.size() == 0) chk("unexpected_update", 0, msg_ctrl, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_msg", msg_ctrl == e.m, msg_ctrl, e.m);
          chk("sb_ctr", ctr_ctrl == e.c, ctr_ctrl, e.c);
          chk("sb_dev", deviation == e.d, deviation, e.d);
          chk("sb_sel", out_sel == e.o, out_sel, e.o);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int mutes, busys, upds, first, fl, n;
    int at[4];
    reset_n = 1;
    sw = 16'h0008;
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1;
    fl = 0;
    for (int i = 1; i <= 20 && fl == 0; i++) begin
      @(negedge clk);
      if (!mute) fl = i;
    end
    chk("mute_fall_after_reset", fl == 4, fl, 4);
    chk("busy_low_after_reset", busy == 1'b0, busy, 0);
    run(20, mutes, busys, upds, first);
    chk("no_update_after_reset", upds == 0, upds, 0);
    chk("msg_kept", msg_ctrl == 32'h49D2, msg_ctrl, 32'h49D2);
    push(32'h49D2, 32'h1F751, 5'h08, 2'b01);
    sw = 16'h4008;
    run(30, mutes, busys, upds, first);
    chk("latency", first >= 15 && first <= 17, first, 16);
    chk("seq_count_4008", upds == 1, upds, 1);
    chk("mute_len", mutes == 9, mutes, 9);
    chk("busy_len", busys == 9, busys, 9);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) sw[13:12] = (sw[13:12] == 2'b01) ? 2'b10 : 2'b01;
      @(negedge clk);
      if (mute || cfg_update) chk("quiet_during_bounce", 0, i, 0);
    end
    push(32'h93A4, 32'h1F751, 5'h08, 2'b01);
    sw[13:12] = 2'b01;
    run(35, mutes, busys, upds, first);
    chk("bounce_one_seq", upds == 1, upds, 1);
    chk("bounce_mute_len", mutes == 9, mutes, 9);
    sw = sw ^ 16'h03E0;
    run(30, mutes, busys, upds, first);
    chk("ignored_no_mute", mutes == 0, mutes, 0);
    chk("ignored_no_busy", busys == 0, busys, 0);
    chk("ignored_no_update", upds == 0, upds, 0);
    push(32'h24E9, 32'h1F751, 5'h08, 2'b00);
    push(32'h49D2, 32'h1F751, 5'h08, 2'b00);
    push(32'h93A4, 32'h1F751, 5'h08, 2'b00);
    push(32'h24E9, 32'h1F751, 5'h08, 2'b00);
    sw = 16'h3008;
    n = 0;
    for (int i = 1; i <= 150 && n < 4; i++) begin
      @(negedge clk);
      if (cfg_update) begin
        at[n] = i;
        n++;
      end
    end
    push(32'h49D2, 32'h1F751, 5'h08, 2'b00);
    sw = 16'h0C08;
    chk("sweep_updates", n == 4, n, 4);
    for (int k = 1; k < 4; k++) chk("sweep_interval", at[k] - at[k-1] == 26, at[k] - at[k-1], 26);
    wait_upd("timeout_0c08", 40);
    @(negedge clk);
    push(32'h49D2, 32'h1F751, 5'h08, 2'b00);
    reset_n = 0;
    #1 chk_reset_vals("mid_reset_0c08");
    @(negedge clk);
    reset_n = 1;
    run(40, mutes, busys, upds, first);
    chk("post_reset_seq", upds == 1, upds, 1);
    push(32'h49D2, 32'h3EEA2, 5'h18, 2'b10);
    sw = 16'h8418;
    wait_upd("timeout_8418", 40);
    @(negedge clk);
    sw = 16'h0008;
    reset_n = 0;
    #1 chk_reset_vals("mid_reset_8418");
    @(negedge clk);
    reset_n = 1;
    run(30, mutes, busys, upds, first);
    chk("no_seq_after_reset", upds == 0, upds, 0);
    chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
